// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified instruction/data memory between the Fetch
// stage (instruction reads) and the Memory stage (loads/stores). Each access
// is granted in IDLE, then timed through a fixed-latency memory by a down
// counter in BUSY. The read data, or a store acknowledge, goes back to the
// requester that owns the access. Only one access is outstanding at a time.
//
// Optional feature: define MEM_ARB_RR_EN to replace fixed data-stage priority
// with alternating priority on simultaneous requests.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DAT_WIDTH-1:0]  if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DAT_WIDTH-1:0]  dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DAT_WIDTH-1:0]  dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DAT_WIDTH-1:0]  mem_wdata,
  input  logic [DAT_WIDTH-1:0]  mem_rdata,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             owner_dm;
  logic             owner_we;
  logic             win_if;
  logic             win_dm;
  logic             access_done;

`ifdef MEM_ARB_RR_EN
  logic             last_dm;

  // Remember who won the most recent arbitration so a tie goes to the other side
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_dm <= 1'b0;
    end else if (win_dm) begin
      last_dm <= 1'b1;
    end else if (win_if) begin
      last_dm <= 1'b0;
    end
  end
`endif

  // Pick a winner in IDLE; a tie goes to the data stage unless alternating priority is enabled
  always_comb begin
    win_if = 1'b0;
    win_dm = 1'b0;
    if (state == IDLE) begin
      if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
        if (last_dm) begin
          win_if = 1'b1;
        end else begin
          win_dm = 1'b1;
        end
`else
        win_dm = 1'b1;
`endif
      end else if (dm_req) begin
        win_dm = 1'b1;
      end else if (if_req) begin
        win_if = 1'b1;
      end
    end
  end

  // The access completes in the BUSY cycle where the latency counter has drained
  always_comb begin
    access_done = (state == BUSY) && (cnt == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a win starts an access, a drained counter ends it
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (win_if || win_dm) state_next = BUSY;
      BUSY: if (access_done)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Issue side: one-cycle grant and memory strobe, with address/data captured from the winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt <= 1'b0;
      dm_gnt <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (win_dm) begin
        dm_gnt    <= 1'b1;
        mem_en    <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (win_if) begin
        if_gnt    <= 1'b1;
        mem_en    <= 1'b1;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
    end
  end

  // Ownership and latency counter: loaded on a grant, counted down while the memory works
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      owner_dm <= 1'b0;
      owner_we <= 1'b0;
    end else if (win_dm || win_if) begin
      cnt      <= CNT_LOAD;
      owner_dm <= win_dm;
      owner_we <= win_dm && dm_we;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // Response side: only the owner's rvalid pulses and only its rdata changes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if (access_done) begin
        if (owner_dm) begin
          dm_rvalid <= 1'b1;
          dm_rdata  <= owner_we ? '0 : mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
    end
  end

  // Busy flag follows the FSM state
  always_comb begin
    busy_o = (state == BUSY);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a per-cycle vector table on a
// MEM_LAT=2 instance, then hand-written sequences for reset during an access,
// tie-breaking under continuous requests (fixed or MEM_ARB_RR_EN priority),
// and the MEM_LAT=1 boundary on a second instance.
module tb_mem_port_arbiter;

  localparam logic [31:0] IW0  = 32'h0050_0093;
  localparam logic [31:0] IW1  = 32'h00A0_0113;
  localparam logic [31:0] LDW  = 32'hCAFE_0100;
  localparam logic [31:0] STW  = 32'hDEAD_BEEF;
  localparam logic [31:0] JUNK = 32'hBADB_AD00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, busy_o;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        l1_if_req, l1_if_gnt, l1_if_rvalid;
  logic [31:0] l1_if_addr, l1_if_rdata;
  logic        l1_dm_req, l1_dm_we, l1_dm_gnt, l1_dm_rvalid;
  logic [31:0] l1_dm_addr, l1_dm_wdata, l1_dm_rdata;
  logic        l1_mem_en, l1_mem_we, l1_busy_o;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy_o(busy_o)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt),
    .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
    .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
    .dm_gnt(l1_dm_gnt), .dm_rvalid(l1_dm_rvalid), .dm_rdata(l1_dm_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy_o(l1_busy_o)
  );

  // Memory macro models: word arrays with a read pipeline of MEM_LAT stages;
  // read data is only meaningful in the single cycle it is due, JUNK otherwise
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [31:0] pipe_a [0:1];
  logic [31:0] pipe_b;
  bit          mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) begin
        mem_a[i] = 32'h0;
        mem_b[i] = 32'h0;
      end
      mem_a[16] = IW0; mem_a[17] = IW1; mem_a[64] = LDW;
      mem_b[16] = IW0; mem_b[17] = IW1; mem_b[64] = LDW;
      mem_ready = 1'b1;
    end
    if (mem_en && mem_we) mem_a[mem_addr[11:2]] = mem_wdata;
    if (l1_mem_en && l1_mem_we) mem_b[l1_mem_addr[11:2]] = l1_mem_wdata;
    pipe_a[0] <= (mem_en && !mem_we) ? mem_a[mem_addr[11:2]] : JUNK;
    pipe_a[1] <= pipe_a[0];
    pipe_b    <= (l1_mem_en && !l1_mem_we) ? mem_b[l1_mem_addr[11:2]] : JUNK;
  end

  assign mem_rdata    = pipe_a[1];
  assign l1_mem_rdata = pipe_b;

  typedef struct {
    logic        rst_n, if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        e_if_gnt, e_if_rvalid;
    logic [31:0] e_if_rdata;
    logic        e_dm_gnt, e_dm_rvalid;
    logic [31:0] e_dm_rdata;
    logic        e_mem_en, e_mem_we;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(
    input logic [31:0] r, ir, ia, dr, dw, da, dd,
    input logic [31:0] eig, eiv, eird, edg, edv, edrd, eme, emw, ema, emd, eb);
    vec_t v;
    v.rst_n = r[0];  v.if_req = ir[0]; v.if_addr = ia;
    v.dm_req = dr[0]; v.dm_we = dw[0]; v.dm_addr = da; v.dm_wdata = dd;
    v.e_if_gnt = eig[0]; v.e_if_rvalid = eiv[0]; v.e_if_rdata = eird;
    v.e_dm_gnt = edg[0]; v.e_dm_rvalid = edv[0]; v.e_dm_rdata = edrd;
    v.e_mem_en = eme[0]; v.e_mem_we = emw[0]; v.e_mem_addr = ema;
    v.e_mem_wdata = emd; v.e_busy = eb[0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n    = v.rst_n;
    if_req   = v.if_req;
    if_addr  = v.if_addr;
    dm_req   = v.dm_req;
    dm_we    = v.dm_we;
    dm_addr  = v.dm_addr;
    dm_wdata = v.dm_wdata;
  endtask

  task automatic checkRecord(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d.if_gnt", idx),    {31'b0, if_gnt},    {31'b0, v.e_if_gnt});
    checkOutput($sformatf("v%0d.if_rvalid", idx), {31'b0, if_rvalid}, {31'b0, v.e_if_rvalid});
    checkOutput($sformatf("v%0d.if_rdata", idx),  if_rdata,           v.e_if_rdata);
    checkOutput($sformatf("v%0d.dm_gnt", idx),    {31'b0, dm_gnt},    {31'b0, v.e_dm_gnt});
    checkOutput($sformatf("v%0d.dm_rvalid", idx), {31'b0, dm_rvalid}, {31'b0, v.e_dm_rvalid});
    checkOutput($sformatf("v%0d.dm_rdata", idx),  dm_rdata,           v.e_dm_rdata);
    checkOutput($sformatf("v%0d.mem_en", idx),    {31'b0, mem_en},    {31'b0, v.e_mem_en});
    checkOutput($sformatf("v%0d.mem_we", idx),    {31'b0, mem_we},    {31'b0, v.e_mem_we});
    checkOutput($sformatf("v%0d.mem_addr", idx),  mem_addr,           v.e_mem_addr);
    checkOutput($sformatf("v%0d.mem_wdata", idx), mem_wdata,          v.e_mem_wdata);
    checkOutput($sformatf("v%0d.busy_o", idx),    {31'b0, busy_o},    {31'b0, v.e_busy});
  endtask

  initial begin
    int   pulses;
    int   gnt_count;
    logic exp_dm;

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    l1_if_req = 1'b0; l1_if_addr = '0; l1_dm_req = 1'b0; l1_dm_we = 1'b0;
    l1_dm_addr = '0; l1_dm_wdata = '0;
    repeat (2) @(posedge clk);

    // inputs: rst ifreq ifaddr dmreq dmwe dmaddr dmwdata | expected:
    // if_gnt if_rvalid if_rdata dm_gnt dm_rvalid dm_rdata mem_en mem_we mem_addr mem_wdata busy
    // reset, then fetch read of 0x40
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0,    0, 0, 0,   0, 0, 0,   0, 0, 0,     0,   0));
    tbl.push_back(mk(1, 1, 32'h40,0, 0, 0,     0,    0, 0, 0,   0, 0, 0,   0, 0, 0,     0,   0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    1, 0, 0,   0, 0, 0,   1, 0, 32'h40,0,   1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, 0,   0, 0, 0,   0, 0, 32'h40,0,   1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, 0,   0, 0, 0,   0, 0, 32'h40,0,   1));
    // tie: dm load of 0x100 wins, fetch of 0x44 follows
    tbl.push_back(mk(1, 1, 32'h44,1, 0, 32'h100,0,   0, 1, IW0, 0, 0, 0,   0, 0, 32'h40,0,   0));
    tbl.push_back(mk(1, 1, 32'h44,0, 0, 0,     0,    0, 0, IW0, 1, 0, 0,   1, 0, 32'h100,0,  1));
    tbl.push_back(mk(1, 1, 32'h44,0, 0, 0,     0,    0, 0, IW0, 0, 0, 0,   0, 0, 32'h100,0,  1));
    tbl.push_back(mk(1, 1, 32'h44,0, 0, 0,     0,    0, 0, IW0, 0, 0, 0,   0, 0, 32'h100,0,  1));
    tbl.push_back(mk(1, 1, 32'h44,0, 0, 0,     0,    0, 0, IW0, 0, 1, LDW, 0, 0, 32'h100,0,  0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    1, 0, IW0, 0, 0, LDW, 1, 0, 32'h44,0,   1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW0, 0, 0, LDW, 0, 0, 32'h44,0,   1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW0, 0, 0, LDW, 0, 0, 32'h44,0,   1));
    // store of 0xDEADBEEF to 0x200, then load it back
    tbl.push_back(mk(1, 0, 0,     1, 1, 32'h200,STW, 0, 1, IW1, 0, 0, LDW, 0, 0, 32'h44,0,   0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW1, 1, 0, LDW, 1, 1, 32'h200,STW,1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW1, 0, 0, LDW, 0, 0, 32'h200,STW,1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW1, 0, 0, LDW, 0, 0, 32'h200,STW,1));
    tbl.push_back(mk(1, 0, 0,     1, 0, 32'h200,0,   0, 0, IW1, 0, 1, 0,   0, 0, 32'h200,STW,0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW1, 1, 0, 0,   1, 0, 32'h200,0,  1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW1, 0, 0, 0,   0, 0, 32'h200,0,  1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW1, 0, 0, 0,   0, 0, 32'h200,0,  1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW1, 0, 1, STW, 0, 0, 32'h200,0,  0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,     0,    0, 0, IW1, 0, 0, STW, 0, 0, 32'h200,0,  0));

    $display("[TB] vector table: %0d cycles", tbl.size());
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkRecord(i, tbl[i]);
    end

    // reset in the middle of a dm load; a fetch request is held through reset
    $display("[TB] reset during access");
    pulses = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      case (cyc)
        0: begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = '0; end
        1: begin dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h40; end
        2: rst_n = 1'b0;
        4: rst_n = 1'b1;
        5: if_req = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (cyc >= 2 && dm_rvalid === 1'b1) pulses++;
      case (cyc)
        1: begin
          checkOutput("rst.c1.dm_gnt", {31'b0, dm_gnt}, 32'd1);
          checkOutput("rst.c1.busy", {31'b0, busy_o}, 32'd1);
        end
        3: begin
          checkOutput("rst.c3.busy", {31'b0, busy_o}, 32'd0);
          checkOutput("rst.c3.mem_en", {31'b0, mem_en}, 32'd0);
          checkOutput("rst.c3.dm_rdata", dm_rdata, 32'd0);
          checkOutput("rst.c3.if_rdata", if_rdata, 32'd0);
          checkOutput("rst.c3.mem_addr", mem_addr, 32'd0);
        end
        4: checkOutput("rst.c4.if_gnt", {31'b0, if_gnt}, 32'd0);
        5: begin
          checkOutput("rst.c5.if_gnt", {31'b0, if_gnt}, 32'd1);
          checkOutput("rst.c5.mem_addr", mem_addr, 32'h40);
        end
        8: begin
          checkOutput("rst.c8.if_rvalid", {31'b0, if_rvalid}, 32'd1);
          checkOutput("rst.c8.if_rdata", if_rdata, IW0);
        end
        default: ;
      endcase
    end
    checkOutput("rst.dm_rvalid_pulses", pulses, 32'd0);

    // both requesters asserting continuously right after reset
    $display("[TB] continuous tie");
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    gnt_count = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = '0;
      end
      if (cyc == 14) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      @(negedge clk);
      if (if_gnt === 1'b1 || dm_gnt === 1'b1) gnt_count++;
      if ((cyc % 4 == 1) && (cyc <= 13)) begin
`ifdef MEM_ARB_RR_EN
        exp_dm = ((cyc / 4) % 2 == 0);
`else
        exp_dm = 1'b1;
`endif
        checkOutput($sformatf("tie.c%0d.dm_gnt", cyc), {31'b0, dm_gnt}, {31'b0, exp_dm});
        checkOutput($sformatf("tie.c%0d.if_gnt", cyc), {31'b0, if_gnt}, {31'b0, !exp_dm});
      end
    end
    checkOutput("tie.grant_count", gnt_count, 32'd4);

    // MEM_LAT=1 instance: single fetch, then back-to-back dm loads
    $display("[TB] MEM_LAT=1 boundary");
    gnt_count = 0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      @(posedge clk); #1;
      case (cyc)
        0: begin l1_if_req = 1'b1; l1_if_addr = 32'h40; end
        1: l1_if_req = 1'b0;
        3: begin l1_dm_req = 1'b1; l1_dm_we = 1'b0; l1_dm_addr = 32'h100; end
        10: l1_dm_req = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (cyc >= 3 && l1_dm_gnt === 1'b1) gnt_count++;
      case (cyc)
        1: begin
          checkOutput("l1.c1.if_gnt", {31'b0, l1_if_gnt}, 32'd1);
          checkOutput("l1.c1.mem_en", {31'b0, l1_mem_en}, 32'd1);
          checkOutput("l1.c1.busy", {31'b0, l1_busy_o}, 32'd1);
        end
        2: begin
          checkOutput("l1.c2.if_rvalid", {31'b0, l1_if_rvalid}, 32'd0);
          checkOutput("l1.c2.busy", {31'b0, l1_busy_o}, 32'd1);
        end
        3: begin
          checkOutput("l1.c3.if_rvalid", {31'b0, l1_if_rvalid}, 32'd1);
          checkOutput("l1.c3.if_rdata", l1_if_rdata, IW0);
          checkOutput("l1.c3.busy", {31'b0, l1_busy_o}, 32'd0);
        end
        4, 7, 10: checkOutput($sformatf("l1.c%0d.dm_gnt", cyc), {31'b0, l1_dm_gnt}, 32'd1);
        6: begin
          checkOutput("l1.c6.dm_rvalid", {31'b0, l1_dm_rvalid}, 32'd1);
          checkOutput("l1.c6.dm_rdata", l1_dm_rdata, LDW);
        end
        default: ;
      endcase
    end
    checkOutput("l1.dm_grant_count", gnt_count, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
